// File: rtl/priority_encoder_pkg.sv
// Shared types and constants for the streaming priority encoder.
// Holds the FSM state type, the default request width and the index-width helper.
package priority_encoder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic int idx_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/priority_encoder_8to3_stream_if.sv
// Request-in / index-out stream bundle for the priority encoder.
// Handshake: a transfer happens on a rising clk edge where valid & ready are both 1;
// a source holds valid and its payload stable until that edge, and never drops valid early.
interface priority_encoder_8to3_stream_if
    import priority_encoder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    localparam int IDX_W = idx_w(WIDTH);

    logic [WIDTH-1:0] in_vec;
    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_none;
    logic             out_last;
    logic [IDX_W:0]   out_count;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_vec, in_valid, out_ready,
        input  in_ready, out_idx, out_none, out_last, out_count, out_valid
    );

    modport slave (
        input  in_vec, in_valid, out_ready,
        output in_ready, out_idx, out_none, out_last, out_count, out_valid
    );

endinterface

// File: rtl/msb_finder.sv
// Combinational search for the highest set bit of a vector.
// multi flags that further set bits remain below the selected one.
module msb_finder
    import priority_encoder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    localparam int IDX_W = idx_w(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic [WIDTH-1:0] onehot,
    output logic             multi
);

    // Ascending scan: the last set bit seen is the highest one.
    always_comb begin
        idx    = '0;
        onehot = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
                idx       = IDX_W'(i);
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

    assign multi = |(vec & ~onehot);

endmodule

// File: rtl/priority_encoder_8to3_stream.sv
// Accepts a request vector and streams the index of each set bit, highest first.
// An all-zero vector yields a single beat flagged with out_none.
module priority_encoder_8to3_stream
    import priority_encoder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   enable,
    priority_encoder_8to3_stream_if.slave bus,
    output state_t state_dbg
);

    localparam int IDX_W = idx_w(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] cur_mask;
    logic [WIDTH-1:0] pend_nxt;
    logic [WIDTH-1:0] f_onehot;
    logic [IDX_W-1:0] f_idx;
    logic             f_multi;
    logic [IDX_W:0]   in_count;
    logic             accept;
    logic             fire;

    assign bus.in_ready = (state == IDLE) & enable & rst_n;
    assign accept       = bus.in_valid & bus.in_ready;
    assign fire         = bus.out_valid & bus.out_ready;
    assign state_dbg    = state;

    // The finder looks at the value pending will hold next, so the beat it
    // describes can be registered straight into the output flops.
    always_comb begin
        pend_nxt = pending;
        if (state == IDLE && accept) begin
            pend_nxt = bus.in_vec;
        end else if (state == BUSY && fire) begin
            pend_nxt = pending & ~cur_mask;
        end
    end

    always_comb begin
        in_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            in_count = in_count + {{IDX_W{1'b0}}, bus.in_vec[i]};
        end
    end

    msb_finder #(.WIDTH(WIDTH)) u_msb (
        .vec    (pend_nxt),
        .idx    (f_idx),
        .onehot (f_onehot),
        .multi  (f_multi)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            pending       <= '0;
            cur_mask      <= '0;
            bus.out_valid <= 1'b0;
            bus.out_idx   <= '0;
            bus.out_none  <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.out_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state         <= BUSY;
                        pending       <= pend_nxt;
                        cur_mask      <= f_onehot;
                        bus.out_valid <= 1'b1;
                        bus.out_idx   <= f_idx;
                        bus.out_none  <= ~|bus.in_vec;
                        bus.out_last  <= ~f_multi;
                        bus.out_count <= in_count;
                    end
                end
                BUSY: begin
                    if (fire) begin
                        if (bus.out_last) begin
                            state         <= IDLE;
                            pending       <= '0;
                            cur_mask      <= '0;
                            bus.out_valid <= 1'b0;
                            bus.out_idx   <= '0;
                            bus.out_none  <= 1'b0;
                            bus.out_last  <= 1'b0;
                            bus.out_count <= '0;
                        end else begin
                            pending      <= pend_nxt;
                            cur_mask     <= f_onehot;
                            bus.out_idx  <= f_idx;
                            bus.out_last <= ~f_multi;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_priority_encoder_8to3_stream.sv
// Bench for the streaming priority encoder: directed table, corner sequences
// and random vectors checked against an index-list model built from each vector.
module tb_priority_encoder_8to3_stream;
    import priority_encoder_pkg::*;

    logic   clk;
    logic   rst_n;
    logic   enable;
    state_t state_dbg;
    int     checks;
    int     errors;

    priority_encoder_8to3_stream_if #(.WIDTH(8)) bus ();

    priority_encoder_8to3_stream #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one vector and consumes its stream. mode: 0 ready always, 1 random ready,
    // 2 ready pattern 1,0,0. drop_en clears enable right after the accept.
    task automatic run_vec(input logic [7:0] v, input int mode, input bit drop_en,
                           output int beats, output int first_idx);
        logic [2:0] exp_q[$];
        logic [3:0] exp_cnt;
        logic       exp_none;
        logic [2:0] h_idx;
        logic       h_none, h_last;
        logic [3:0] h_count;
        bit         held;
        bit         r;
        int         cyc;
        int         iter;
        int         n_exp;

        exp_q.delete();
        exp_none = (v == 8'h00);
        exp_cnt  = 4'($countones(v));
        if (exp_none) exp_q.push_back(3'd0);
        for (int i = 7; i >= 0; i--) if (v[i]) exp_q.push_back(3'(i));
        n_exp     = exp_q.size();
        beats     = 0;
        first_idx = -1;

        bus.in_vec   = v;
        bus.in_valid = 1'b1;
        cyc = 0;
        while (!bus.in_ready && cyc < 50) begin
            tick();
            cyc++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", 0, 1);
            bus.in_valid = 1'b0;
            return;
        end
        tick();
        bus.in_valid = 1'b0;
        bus.in_vec   = 8'($urandom);
        if (drop_en) enable = 1'b0;
        chk("latency_valid", bus.out_valid, 1);

        held = 0;
        iter = 0;
        while (exp_q.size() > 0 && iter < 200) begin
            if (!bus.out_valid) begin
                chk("valid_held", 0, 1);
                break;
            end
            if (held) begin
                chk("stall_idx", bus.out_idx, h_idx);
                chk("stall_none", bus.out_none, h_none);
                chk("stall_last", bus.out_last, h_last);
                chk("stall_count", bus.out_count, h_count);
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = 1'($urandom_range(0, 1));
                default: r = (iter % 3 == 0);
            endcase
            bus.out_ready = r;
            if (r) begin
                chk("beat_idx", bus.out_idx, exp_q[0]);
                chk("beat_none", bus.out_none, exp_none);
                chk("beat_last", bus.out_last, exp_q.size() == 1);
                chk("beat_count", bus.out_count, exp_cnt);
                if (beats == 0) first_idx = int'(bus.out_idx);
                beats++;
                void'(exp_q.pop_front());
                held = 0;
            end else begin
                held    = 1;
                h_idx   = bus.out_idx;
                h_none  = bus.out_none;
                h_last  = bus.out_last;
                h_count = bus.out_count;
            end
            tick();
            iter++;
        end
        if (exp_q.size() != 0) chk("stream_incomplete", exp_q.size(), 0);
        bus.out_ready = 1'b1;
        chk("valid_after_last", bus.out_valid, 0);
        chk("in_ready_after", bus.in_ready, enable);
        if (mode == 0) chk("throughput_cycles", iter, n_exp);
    endtask

    typedef struct {
        logic [7:0] vec;
        int         mode;
        int         exp_beats;
        int         exp_first;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int beats;
        int first;
        logic [7:0] rv;

        checks = 0;
        errors = 0;
        tbl[0] = '{8'b0000_1000, 0, 1, 3};
        tbl[1] = '{8'b1010_0101, 0, 4, 7};
        tbl[2] = '{8'h00,        0, 1, 0};
        tbl[3] = '{8'hFF,        2, 8, 7};
        tbl[4] = '{8'h80,        1, 1, 7};
        tbl[5] = '{8'h01,        0, 1, 0};
        tbl[6] = '{8'h7E,        1, 6, 6};
        tbl[7] = '{8'h11,        2, 2, 4};

        rst_n         = 1'b0;
        enable        = 1'b1;
        bus.in_vec    = 8'h00;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #12;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_idx", bus.out_idx, 0);
        chk("rst_out_none", bus.out_none, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_out_count", bus.out_count, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_state", state_dbg, IDLE);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        chk("idle_in_ready", bus.in_ready, 1);

        for (int i = 0; i < 8; i++) begin
            run_vec(tbl[i].vec, tbl[i].mode, 1'b0, beats, first);
            chk("tbl_beats", beats, tbl[i].exp_beats);
            chk("tbl_first_idx", first, tbl[i].exp_first);
        end

        // Enable gating: a held request is ignored until enable rises.
        enable       = 1'b0;
        bus.in_vec   = 8'b0000_1000;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("gated_in_ready", bus.in_ready, 0);
            chk("gated_out_valid", bus.out_valid, 0);
        end
        enable = 1'b1;
        run_vec(8'b0000_1000, 0, 1'b0, beats, first);
        chk("gated_first_idx", first, 3);

        // Enable dropped mid-stream: stream finishes, then no accept until re-enabled.
        run_vec(8'hC0, 0, 1'b1, beats, first);
        chk("drop_en_beats", beats, 2);
        chk("drop_en_first", first, 7);
        enable = 1'b1;
        tick();

        // Reset in the middle of an 8'hF0 stream.
        bus.in_vec   = 8'hF0;
        bus.in_valid = 1'b1;
        chk("rst_seq_ready", bus.in_ready, 1);
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("rst_seq_idx7", bus.out_idx, 7);
        tick();
        chk("rst_seq_idx6", bus.out_idx, 6);
        #2 rst_n = 1'b0;
        #1;
        chk("async_out_valid", bus.out_valid, 0);
        chk("async_out_idx", bus.out_idx, 0);
        chk("async_out_count", bus.out_count, 0);
        chk("async_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        run_vec(8'h02, 0, 1'b0, beats, first);
        chk("post_rst_beats", beats, 1);
        chk("post_rst_idx", first, 1);

        for (int n = 0; n < 40; n++) begin
            rv = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) rv = 8'h00;
            run_vec(rv, int'($urandom_range(0, 2)), 1'b0, beats, first);
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
